// File: rtl/vend_controller.sv
// Two-product coin vending controller: credit, stock, vend handshake, change.
// Ports: clk, async_reset_n, coin, sel, cancel, restock, vend_ack in;
//        vend_req, vend_item, change_5, credit, busy, coin_reject, deny,
//        sold_out_a, sold_out_b out (all registered).
module vend_controller #(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 20,
    parameter int MAX_CREDIT = 35,
    parameter int STOCK_INIT = 4
) (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       restock,
    input  logic       vend_ack,
    output logic       vend_req,
    output logic       vend_item,
    output logic       change_5,
    output logic [5:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       deny,
    output logic       sold_out_a,
    output logic       sold_out_b
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam logic [5:0] PA   = 6'(PRICE_A);
    localparam logic [5:0] PB   = 6'(PRICE_B);
    localparam logic [6:0] MAXC = 7'(MAX_CREDIT);
    localparam logic [3:0] SINI = 4'(STOCK_INIT);

    state_t     state;
    logic [3:0] stock_a;
    logic [3:0] stock_b;

    logic       sel_a, sel_b, sel_any;
    logic [5:0] price;
    logic       stock_ok, can_buy;
    logic       cancel_act, sel_act;
    logic [6:0] coin_sum;
    logic       coin_fits;

    always_comb begin
        sel_a      = (sel == 2'b01);
        sel_b      = (sel == 2'b10);
        sel_any    = sel_a | sel_b;
        price      = sel_b ? PB : PA;
        stock_ok   = sel_b ? (stock_b != 4'd0) : (stock_a != 4'd0);
        can_buy    = sel_any && (credit >= price) && stock_ok;
        // cancel with no credit is a no-op, so it does not block a coin
        cancel_act = cancel && (credit != 6'd0);
        sel_act    = !cancel_act && sel_any;
        // 7 bits so credit + 15 cannot wrap before the ceiling test
        coin_sum   = {1'b0, credit} + (7'(coin) * 7'd5);
        coin_fits  = (coin_sum <= MAXC);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state       <= IDLE;
            credit      <= 6'd0;
            stock_a     <= SINI;
            stock_b     <= SINI;
            vend_req    <= 1'b0;
            vend_item   <= 1'b0;
            change_5    <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            sold_out_a  <= (SINI == 4'd0);
            sold_out_b  <= (SINI == 4'd0);
        end else begin
            change_5    <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cancel_act) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= (coin != 2'd0);
                    end else if (sel_act) begin
                        coin_reject <= (coin != 2'd0);
                        if (can_buy) begin
                            credit    <= credit - price;
                            vend_item <= sel_b;
                            vend_req  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= VEND;
                            if (sel_b) begin
                                stock_b    <= stock_b - 4'd1;
                                sold_out_b <= (stock_b == 4'd1);
                            end else begin
                                stock_a    <= stock_a - 4'd1;
                                sold_out_a <= (stock_a == 4'd1);
                            end
                        end else begin
                            deny <= 1'b1;
                        end
                    end else if (coin != 2'd0) begin
                        if (coin_fits) begin
                            credit <= coin_sum[5:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (restock) begin
                        stock_a    <= SINI;
                        stock_b    <= SINI;
                        sold_out_a <= (SINI == 4'd0);
                        sold_out_b <= (SINI == 4'd0);
                    end
                end
                VEND: begin
                    coin_reject <= (coin != 2'd0);
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        if (credit != 6'd0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= (coin != 2'd0);
                    if (credit == 6'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        change_5 <= 1'b1;
                        credit   <= credit - 6'd5;
                        if (credit == 6'd5) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller with default parameters.
// Drives one-cycle stimulus vectors and checks registered outputs after each edge.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       async_reset_n = 1'b0;
    logic [1:0] coin = 2'd0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       vend_ack = 1'b0;
    logic       vend_req, vend_item, change_5, busy;
    logic       coin_reject, deny, sold_out_a, sold_out_b;
    logic [5:0] credit;

    int checks = 0;
    int failures = 0;

    vend_controller dut (
        .clk(clk),
        .async_reset_n(async_reset_n),
        .coin(coin),
        .sel(sel),
        .cancel(cancel),
        .restock(restock),
        .vend_ack(vend_ack),
        .vend_req(vend_req),
        .vend_item(vend_item),
        .change_5(change_5),
        .credit(credit),
        .busy(busy),
        .coin_reject(coin_reject),
        .deny(deny),
        .sold_out_a(sold_out_a),
        .sold_out_b(sold_out_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // apply one vector for exactly one rising edge, then idle the inputs
    task automatic cyc(input logic [1:0] c, input logic [1:0] s,
                       input logic cn, input logic rs, input logic ak);
        coin = c; sel = s; cancel = cn; restock = rs; vend_ack = ak;
        @(posedge clk);
        #1;
        coin = 2'd0; sel = 2'd0; cancel = 1'b0;
        restock = 1'b0; vend_ack = 1'b0;
    endtask

    // count change pulses until busy drops; pulses must be back-to-back
    task automatic drain(input string tag, input int exp_pulses);
        int pulses = 0;
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            n++;
            if (change_5) pulses++;
            if (!busy) break;
        end
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_nogap"}, n, exp_pulses);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_credit"}, credit, 0);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check({tag, "_c5_low"}, change_5, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_vreq", vend_req, 0);
        check("rst_c5", change_5, 0);
        check("rst_soa", sold_out_a, 0);
        check("rst_sob", sold_out_b, 0);
        async_reset_n = 1'b1;

        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("ack_idle_busy", busy, 0);
        check("ack_idle_vreq", vend_req, 0);

        // vend A with exact credit, no change
        cyc(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t1_c5", credit, 5);
        cyc(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t1_c15", credit, 15);
        cyc(2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t1_vreq", vend_req, 1);
        check("t1_item", vend_item, 0);
        check("t1_credit", credit, 0);
        check("t1_busy", busy, 1);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t1_vreq_off", vend_req, 0);
        check("t1_idle", busy, 0);
        check("t1_noc5", change_5, 0);

        // vend B with 5 units change
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t2_c25", credit, 25);
        cyc(2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t2_item", vend_item, 1);
        check("t2_credit", credit, 5);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t2_vreq_off", vend_req, 0);
        check("t2_change", busy, 1);
        drain("t2", 1);

        // overflow reject then cancel refund
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t3_c30", credit, 30);
        cyc(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t3_rej", coin_reject, 1);
        check("t3_c30b", credit, 30);
        cyc(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("t3_rej_off", coin_reject, 0);
        check("t3_busy", busy, 1);
        drain("t3", 6);

        // deny on low credit; deny plus coin reject together
        cyc(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t4_deny", deny, 1);
        check("t4_credit", credit, 10);
        check("t4_idle", busy, 0);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t4_deny_off", deny, 0);
        cyc(2'd2, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t4_deny2", deny, 1);
        check("t4_rej", coin_reject, 1);
        check("t4_credit2", credit, 10);
        cyc(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        drain("t4", 2);

        // stock exhaustion of A and restock
        cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
            cyc(2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
            check("t5_vreq", vend_req, 1);
            check("t5_soa", sold_out_a, (i == 4) ? 1 : 0);
            cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        end
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t5_deny", deny, 1);
        check("t5_novend", vend_req, 0);
        check("t5_credit", credit, 15);
        cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("t5_restock", sold_out_a, 0);
        cyc(2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t5_vend_again", vend_req, 1);
        check("t5_credit0", credit, 0);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

        // exact ceiling accepted, one more rejected
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("max_c35", credit, 35);
        check("max_norej", coin_reject, 0);
        cyc(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("max_rej", coin_reject, 1);
        check("max_c35b", credit, 35);
        cyc(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        drain("max", 7);

        // coins during VEND/CHANGE, then reset mid-change
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t6_credit10", credit, 10);
        cyc(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t6_rej_vend", coin_reject, 1);
        check("t6_cr_vend", credit, 10);
        check("t6_vreq_hold", vend_req, 1);
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("t6_change", busy, 1);
        cyc(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t6_rej_chg", coin_reject, 1);
        check("t6_c5", change_5, 1);
        check("t6_cr_chg", credit, 5);
        #2;
        async_reset_n = 1'b0;
        #1;
        check("t6_rst_credit", credit, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_c5", change_5, 0);
        check("t6_rst_sob", sold_out_b, 0);
        @(posedge clk);
        #1;
        async_reset_n = 1'b1;
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t6_post_c5", change_5, 0);
        check("t6_post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
